// File: rtl/i2c_target_resp.sv
// I2C target: oversampled SCL/SDA, START/STOP detection, 7-bit address match, byte write/read.
// Optional glitch filter on both lines when I2C_TGT_GLITCH_FILTER_EN is defined.
module i2c_target_resp #(
  parameter logic [6:0] TGT_ADDR = 7'h50,
  parameter int         FILT_LEN = 4
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_t,
  output logic [7:0] wr_data,
  output logic       wr_valid,
  output logic       rd_req,
  input  logic [7:0] rd_data,
  output logic       busy,
  output logic       nack_seen
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  if (FILT_LEN < 2 || FILT_LEN > 15) begin : g_filt_len_check
    $error("FILT_LEN must be in 2..15");
  end

  logic [1:0] scl_sync, sda_sync;
  logic       scl_s, sda_s;
  logic       scl_d, sda_d;
  logic       scl_rise, scl_fall, start_det, stop_det;

  // Stage: two-flop synchronizers; idle bus level is high
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
    end
  end

`ifdef I2C_TGT_GLITCH_FILTER_EN
  localparam logic [3:0] FILT_LAST = 4'(FILT_LEN - 1);
  logic [3:0] scl_cnt, sda_cnt;
  logic       scl_f, sda_f;

  // Stage: a line follows its input only after FILT_LEN consecutive differing samples
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      scl_cnt <= '0;
      sda_cnt <= '0;
      scl_f   <= 1'b1;
      sda_f   <= 1'b1;
    end else begin
      if (scl_sync[1] == scl_f) begin
        scl_cnt <= '0;
      end else if (scl_cnt == FILT_LAST) begin
        scl_f   <= scl_sync[1];
        scl_cnt <= '0;
      end else begin
        scl_cnt <= scl_cnt + 4'd1;
      end
      if (sda_sync[1] == sda_f) begin
        sda_cnt <= '0;
      end else if (sda_cnt == FILT_LAST) begin
        sda_f   <= sda_sync[1];
        sda_cnt <= '0;
      end else begin
        sda_cnt <= sda_cnt + 4'd1;
      end
    end
  end

  assign scl_s = scl_f;
  assign sda_s = sda_f;
`else
  assign scl_s = scl_sync[1];
  assign sda_s = sda_sync[1];
`endif

  // Stage: delayed copies for edge and bus-condition detection
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_s;
      sda_d <= sda_s;
    end
  end

  assign scl_rise  =  scl_s & ~scl_d;
  assign scl_fall  = ~scl_s &  scl_d;
  assign start_det =  scl_s &  scl_d &  sda_d & ~sda_s;
  assign stop_det  =  scl_s &  scl_d & ~sda_d &  sda_s;

  state_t     state, state_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic       ack_on, ack_on_nxt;
  logic       rw, rw_nxt;
  logic       lead, lead_nxt;
  logic       rd_req_d1;
  logic [6:0] rx_sh, rx_sh_nxt;
  logic [7:0] tx_byte;
  logic       sda_t_nxt, busy_nxt;
  logic [7:0] wr_data_nxt;
  logic       wr_valid_nxt, rd_req_nxt, nack_seen_nxt;

  // Stage: control and output registers
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      ack_on    <= 1'b0;
      rw        <= 1'b0;
      lead      <= 1'b0;
      rd_req_d1 <= 1'b0;
      sda_t     <= 1'b1;
      busy      <= 1'b0;
      wr_data   <= '0;
      wr_valid  <= 1'b0;
      rd_req    <= 1'b0;
      nack_seen <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      ack_on    <= ack_on_nxt;
      rw        <= rw_nxt;
      lead      <= lead_nxt;
      rd_req_d1 <= rd_req;
      sda_t     <= sda_t_nxt;
      busy      <= busy_nxt;
      wr_data   <= wr_data_nxt;
      wr_valid  <= wr_valid_nxt;
      rd_req    <= rd_req_nxt;
      nack_seen <= nack_seen_nxt;
    end
  end

  // Stage: shift data; the read byte is captured two cycles after rd_req
  always_ff @(posedge CLK) begin
    rx_sh <= rx_sh_nxt;
    if (rd_req_d1) tx_byte <= rd_data;
  end

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    ack_on_nxt    = ack_on;
    rw_nxt        = rw;
    lead_nxt      = lead;
    rx_sh_nxt     = rx_sh;
    sda_t_nxt     = sda_t;
    busy_nxt      = busy;
    wr_data_nxt   = wr_data;
    wr_valid_nxt  = 1'b0;
    rd_req_nxt    = 1'b0;
    nack_seen_nxt = 1'b0;

    if (start_det) begin
      state_nxt   = ADDR;
      bit_cnt_nxt = '0;
      ack_on_nxt  = 1'b0;
      lead_nxt    = 1'b0;
      sda_t_nxt   = 1'b1;
    end else if (stop_det) begin
      state_nxt   = IDLE;
      bit_cnt_nxt = '0;
      ack_on_nxt  = 1'b0;
      lead_nxt    = 1'b0;
      sda_t_nxt   = 1'b1;
      busy_nxt    = 1'b0;
    end else begin
      unique case (state)
        IDLE: sda_t_nxt = 1'b1;
        ADDR: begin
          if (scl_rise) begin
            rx_sh_nxt   = {rx_sh[5:0], sda_s};
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (rx_sh == TGT_ADDR) begin
                state_nxt  = ADDR_ACK;
                busy_nxt   = 1'b1;
                rw_nxt     = sda_s;
                ack_on_nxt = 1'b0;
              end else begin
                state_nxt = IGNORE;
                busy_nxt  = 1'b0;
              end
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!ack_on) begin
              // Request the first read byte as the ACK starts so it is ready for bit 7
              sda_t_nxt  = 1'b0;
              ack_on_nxt = 1'b1;
              rd_req_nxt = rw;
            end else begin
              ack_on_nxt  = 1'b0;
              bit_cnt_nxt = '0;
              lead_nxt    = 1'b0;
              if (rw) begin
                state_nxt = RD_DATA;
                sda_t_nxt = tx_byte[7];
              end else begin
                state_nxt = WR_DATA;
                sda_t_nxt = 1'b1;
              end
            end
          end
        end
        WR_DATA: begin
          if (scl_rise) begin
            rx_sh_nxt   = {rx_sh[5:0], sda_s};
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              wr_data_nxt  = {rx_sh, sda_s};
              wr_valid_nxt = 1'b1;
              state_nxt    = WR_ACK;
              ack_on_nxt   = 1'b0;
            end
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            if (!ack_on) begin
              sda_t_nxt  = 1'b0;
              ack_on_nxt = 1'b1;
            end else begin
              sda_t_nxt  = 1'b1;
              ack_on_nxt = 1'b0;
              state_nxt  = WR_DATA;
            end
          end
        end
        RD_DATA: begin
          if (scl_fall) begin
            if (lead) begin
              sda_t_nxt = tx_byte[7];
              lead_nxt  = 1'b0;
            end else if (bit_cnt == 3'd7) begin
              sda_t_nxt   = 1'b1;
              bit_cnt_nxt = '0;
              state_nxt   = RD_ACK;
            end else begin
              sda_t_nxt   = tx_byte[3'd6 - bit_cnt];
              bit_cnt_nxt = bit_cnt + 3'd1;
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              rd_req_nxt  = 1'b1;
              state_nxt   = RD_DATA;
              lead_nxt    = 1'b1;
              bit_cnt_nxt = '0;
            end else begin
              nack_seen_nxt = 1'b1;
              state_nxt     = IGNORE;
              busy_nxt      = 1'b0;
            end
          end
        end
        IGNORE: begin
          sda_t_nxt = 1'b1;
          busy_nxt  = 1'b0;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target_resp.sv
// Directed bench for i2c_target_resp: an open-drain bus controller model plus a read-data responder.
`timescale 1ns/1ps
module tb_i2c_target_resp;

  localparam int Q = 20;

  logic       CLK = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_ctrl = 1'b1;
  logic       sda_line;
  logic [7:0] rd_data = 8'h00;
  logic       sda_t, wr_valid, rd_req, busy, nack_seen;
  logic [7:0] wr_data;

  int tests = 0;
  int fails = 0;

  int         wr_pulses = 0, rd_pulses = 0, nack_pulses = 0, sda_low_cnt = 0;
  logic [7:0] wr_log [0:15];
  logic [7:0] rd_vals [0:3];
  int         rd_idx = 0;

  assign sda_line = sda_ctrl & sda_t;

  always #10 CLK = ~CLK;

  i2c_target_resp dut (
    .CLK      (CLK),
    .rst_n    (rst_n),
    .scl_i    (scl),
    .sda_i    (sda_line),
    .sda_t    (sda_t),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .rd_req   (rd_req),
    .rd_data  (rd_data),
    .busy     (busy),
    .nack_seen(nack_seen)
  );

  always @(negedge CLK) begin
    if (wr_valid) begin
      wr_log[wr_pulses[3:0]] <= wr_data;
      wr_pulses <= wr_pulses + 1;
    end
    if (rd_req) rd_pulses <= rd_pulses + 1;
    if (nack_seen) nack_pulses <= nack_pulses + 1;
    if (!sda_t) sda_low_cnt <= sda_low_cnt + 1;
  end

  // Read data is valid only in the single cycle that ends 2 CLK after rd_req
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge CLK);
      if (ph == 1) begin
        rd_data = rd_vals[rd_idx[1:0]];
        ph = 2;
      end else if (ph == 2) begin
        rd_data = ~rd_vals[rd_idx[1:0]];
        rd_idx = rd_idx + 1;
        ph = 0;
      end
      if (rd_req && ph == 0) ph = 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic bus_start();
    sda_ctrl = 1'b0;
    wait_clk(Q);
    scl = 1'b0;
  endtask

  task automatic bus_rstart();
    wait_clk(Q);
    sda_ctrl = 1'b1;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    sda_ctrl = 1'b0;
    wait_clk(Q);
    scl = 1'b0;
  endtask

  task automatic bus_stop();
    wait_clk(Q);
    sda_ctrl = 1'b0;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    sda_ctrl = 1'b1;
    wait_clk(Q);
  endtask

  task automatic bit_io(input logic b, input logic glitch, output logic s);
    wait_clk(Q);
    sda_ctrl = b;
    wait_clk(Q);
    scl = 1'b1;
    if (glitch) begin
      wait_clk(5);
      scl = 1'b0;
      wait_clk(2);
      scl = 1'b1;
      wait_clk(Q - 7);
    end else begin
      wait_clk(Q);
    end
    s = sda_line;
    wait_clk(Q);
    scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic glitch, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_io(b[i], glitch && (i == 7), s);
    bit_io(1'b1, 1'b0, s);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, 1'b0, s);
      b[i] = s;
    end
    bit_io(nack, 1'b0, s);
  endtask

  initial begin
    logic       ack, s;
    logic [7:0] rb;
    int         wb, rb0, nb0, lb;

    rd_vals[0] = 8'hC3;
    rd_vals[1] = 8'h5A;
    rd_vals[2] = 8'h96;
    rd_vals[3] = 8'h00;

    // Reset state
    wait_clk(3);
    chk("rst_sda_t", sda_t, 1'b1);
    chk("rst_wr_data", wr_data, 8'h00);
    chk("rst_wr_valid", wr_valid, 1'b0);
    chk("rst_rd_req", rd_req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_nack_seen", nack_seen, 1'b0);
    rst_n = 1'b1;
    wait_clk(5);

    // Write 0xA5, 0x3C to 0x50
    wb = wr_pulses;
    bus_start();
    send_byte(8'hA0, 1'b0, ack);
    chk("wr_addr_ack", ack, 1'b1);
    chk("wr_busy", busy, 1'b1);
    send_byte(8'hA5, 1'b0, ack);
    chk("wr_b1_ack", ack, 1'b1);
    send_byte(8'h3C, 1'b0, ack);
    chk("wr_b2_ack", ack, 1'b1);
    bus_stop();
    chk("wr_busy_stop", busy, 1'b0);
    chk("wr_pulses", wr_pulses - wb, 2);
    chk("wr_data1", wr_log[wb[3:0]], 8'hA5);
    chk("wr_data2", wr_log[4'(wb + 1)], 8'h3C);

    // Write to non-matching 0x51
    wb = wr_pulses;
    lb = sda_low_cnt;
    bus_start();
    send_byte(8'hA2, 1'b0, ack);
    chk("miss_addr_ack", ack, 1'b0);
    chk("miss_busy", busy, 1'b0);
    send_byte(8'h55, 1'b0, ack);
    chk("miss_data_ack", ack, 1'b0);
    bus_stop();
    chk("miss_sda_low", sda_low_cnt - lb, 0);
    chk("miss_wr_pulses", wr_pulses - wb, 0);

    // Read two bytes, ACK then NACK
    rb0 = rd_pulses;
    nb0 = nack_pulses;
    bus_start();
    send_byte(8'hA1, 1'b0, ack);
    chk("rd_addr_ack", ack, 1'b1);
    recv_byte(1'b0, rb);
    chk("rd_byte1", rb, 8'hC3);
    recv_byte(1'b1, rb);
    chk("rd_byte2", rb, 8'h5A);
    chk("rd_req_pulses", rd_pulses - rb0, 2);
    chk("rd_nack_pulses", nack_pulses - nb0, 1);
    chk("rd_sda_t_after_nack", sda_t, 1'b1);
    chk("rd_busy_after_nack", busy, 1'b0);
    bus_stop();

    // Write 0x10, repeated START, read one byte
    wb = wr_pulses;
    bus_start();
    send_byte(8'hA0, 1'b0, ack);
    send_byte(8'h10, 1'b0, ack);
    chk("rs_wr_ack", ack, 1'b1);
    bus_rstart();
    chk("rs_busy_held", busy, 1'b1);
    send_byte(8'hA1, 1'b0, ack);
    chk("rs_addr_ack", ack, 1'b1);
    recv_byte(1'b1, rb);
    chk("rs_rd_byte", rb, 8'h96);
    bus_stop();
    chk("rs_wr_data", wr_log[wb[3:0]], 8'h10);
    chk("rs_busy_stop", busy, 1'b0);

    // Asynchronous reset while the address ACK is driven
    bus_start();
    for (int i = 7; i >= 0; i--) bit_io(i == 0 ? 1'b0 : (i == 7 || i == 5), 1'b0, s);
    wait_clk(10);
    chk("arst_pre_ack_drive", sda_t, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_sda_t", sda_t, 1'b1);
    chk("arst_busy", busy, 1'b0);
    wait_clk(3);
    rst_n = 1'b1;
    wb = wr_pulses;
    lb = sda_low_cnt;
    bit_io(1'b1, 1'b0, s);
    send_byte(8'h77, 1'b0, ack);
    bus_stop();
    chk("arst_ignored_sda", sda_low_cnt - lb, 0);
    chk("arst_ignored_wr", wr_pulses - wb, 0);
    bus_start();
    send_byte(8'hA0, 1'b0, ack);
    chk("arst_next_addr_ack", ack, 1'b1);
    send_byte(8'h5C, 1'b0, ack);
    chk("arst_next_data_ack", ack, 1'b1);
    bus_stop();
    chk("arst_next_wr_data", wr_log[wb[3:0]], 8'h5C);

    // 40 ns SCL glitch during the MSB of a write byte
    wb = wr_pulses;
    bus_start();
    send_byte(8'hA0, 1'b0, ack);
    send_byte(8'hA5, 1'b1, ack);
    bus_stop();
    chk("glitch_wr_pulses", wr_pulses - wb, 1);
`ifdef I2C_TGT_GLITCH_FILTER_EN
    chk("glitch_wr_data", wr_log[wb[3:0]], 8'hA5);
`else
    chk("glitch_wr_data", wr_log[wb[3:0]], 8'hD2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2c_target_resp.md
Name: i2c_target_resp

Overview:
- I2C target (responder) for the FMC424 I2C path; the far end of the bus from the 100 kHz SCL generator and controller.
- Oversamples SCL/SDA on the 50 MHz fabric clock, detects START/STOP, and matches a 7-bit address.
- Acknowledges the address and write bytes; serves read bytes from a local byte interface.
- Drives SDA open-drain through the IOBUF T pin; never drives SCL.

Parameters:
- TGT_ADDR, 7'h50, 7-bit target address matched after START.
- FILT_LEN, 4, number of consecutive equal samples required by the optional glitch filter (range 2..15).

Ports:
- CLK  in  1  fabric clock, 50 MHz.
- rst_n  in  1  reset; one clock domain, asynchronous assert, active-low.
- scl_i  in  1  SCL from IOBUF O; asynchronous to CLK.
- sda_i  in  1  SDA from IOBUF O; asynchronous to CLK.
- sda_t  out  1  IOBUF T for SDA, with IOBUF I tied 0. Value 1 = release (high-Z), 0 = pull low.
- wr_data  out  8  last byte written by the controller.
- wr_valid  out  1  one-CLK pulse; wr_data is valid in the same cycle.
- rd_req  out  1  one-CLK pulse requesting the next read byte.
- rd_data  in  8  read byte; sampled exactly 2 CLK after rd_req.
- busy  out  1  high from an address-matched START until STOP or IGNORE.
- nack_seen  out  1  one-CLK pulse when the controller NACKs a read byte.

Behaviour:
- Reset values (rst_n=0): sda_t=1, wr_data=0, wr_valid=0, rd_req=0, busy=0, nack_seen=0. State=IDLE, bit counter=0.
- Reset is asynchronous. Deasserting rst_n mid-transfer returns to IDLE with SDA released; the block then waits for the next START.
- Input conditioning: scl_i and sda_i each pass through a 2-FF synchronizer, plus the optional filter, giving scl_s and sda_s.
- Edge and condition detection uses a registered copy of scl_s and sda_s:
  - scl_rise / scl_fall: edges of scl_s.
  - START: sda_s 1->0 while scl_s=1.
  - STOP: sda_s 0->1 while scl_s=1.
- SDA sampling and driving:
  - SDA is sampled on scl_rise.
  - sda_t changes only on scl_fall, 1 CLK after it is detected.
- States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
- START in any state (including repeated START): go to ADDR, clear bit counter, sda_t=1.
- STOP in any state: go to IDLE, sda_t=1, busy=0.
- STOP or START has priority over the shift logic when detected in the same CLK.
- ADDR:
  - Shift 8 bits, MSB first, on scl_rise.
  - After bit 8: if bits[7:1]==TGT_ADDR go to ADDR_ACK and set busy=1; otherwise go to IGNORE.
  - The R/W bit is bits[0]; 1 = read.
- ADDR_ACK:
  - At the next scl_fall, sda_t=0.
  - At the following scl_fall, for a write go to WR_DATA with sda_t=1.
  - For a read go to RD_DATA: pulse rd_req at the scl_fall that enters ADDR_ACK's second half, latch rd_data 2 CLK later, and drive bit7 on that same scl_fall.
  - Bit7 driving: sda_t = rd_data[7] ? 1 : 0.
- WR_DATA:
  - Shift 8 bits on scl_rise.
  - On the 8th rise, update wr_data and pulse wr_valid.
  - Go to WR_ACK and drive ACK (sda_t=0) for one SCL period (scl_fall to scl_fall), then return to WR_DATA.
  - All writes are ACKed.
- RD_DATA:
  - Bits 6..0 are presented on successive scl_fall.
  - After the 8th bit's scl_fall, sda_t=1 and go to RD_ACK.
- RD_ACK: sample SDA on scl_rise.
  - 0 (ACK): pulse rd_req, load the next byte, return to RD_DATA.
  - 1 (NACK): pulse nack_seen, go to IGNORE.
- IGNORE: sda_t=1, busy=0; wait for START or STOP.
- Bit counter: 3 bits, wraps 7->0 at each byte boundary. Reloaded to 0 on START.
- The block never stretches SCL; rd_data must be stable at rd_req+2.

Optional Feature:
- Macro: I2C_TGT_GLITCH_FILTER_EN.
- Defined: after the synchronizer, each line updates only after FILT_LEN consecutive equal samples. This adds FILT_LEN CLK latency and rejects pulses shorter than FILT_LEN CLK (80 ns at default).
- Undefined: scl_s/sda_s are the raw 2-FF synchronizer outputs, with no filter logic generated.

Test Plan:
- Write to 0x50 of bytes 0xA5, 0x3C, then STOP -> three ACKs on SDA; wr_valid pulses twice with wr_data=0xA5 then 0x3C; busy falls after STOP.
- Write to address 0x51 -> no ACK (sda_t stays 1 throughout), no wr_valid, busy stays 0; IGNORE until STOP.
- Read from 0x50 with rd_data=0xC3 then 0x5A; controller ACKs byte 1 and NACKs byte 2 -> SDA bits 11000011 then 01011010; two rd_req pulses; one nack_seen; sda_t=1 after NACK.
- Write 0x50 of 0x10, then repeated START, then read -> wr_valid with 0x10, re-enters ADDR without STOP, read proceeds normally.
- rst_n low mid-byte during ADDR_ACK while sda_t=0 -> sda_t=1 immediately (async); after release, ignores bus until next START; next transfer succeeds.
- With I2C_TGT_GLITCH_FILTER_EN: 40 ns low glitch on SCL high during a data bit -> no extra bit shifted, byte intact. Without the macro, the same glitch is allowed to corrupt the byte (confirm the build difference).
